// File: rtl/pipe_chain_if.sv
// pipe_chain_if: stage-boundary bus for the pipeline register chain
interface pipe_chain_if #(
    parameter int WIDTH    = 259,
    parameter int DEPTH    = 1,
    parameter int STALL_WD = 7,
    parameter int EXC_WD   = 3,
    parameter int CNT_WD   = 16
);
    logic                         flush;
    logic [STALL_WD-1:0]          stall;
    logic [WIDTH-1:0]             in_bus;
    logic                         in_valid;
    logic [EXC_WD-1:0]            exc_in;
    logic [WIDTH-1:0]             out_bus;
    logic                         out_valid;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    logic [CNT_WD-1:0]            bubble_cnt;
    modport master (
        output flush, stall, in_bus, in_valid, exc_in,
        input  out_bus, out_valid, occupancy, bubble_cnt
    );
    modport slave (
        input  flush, stall, in_bus, in_valid, exc_in,
        output out_bus, out_valid, occupancy, bubble_cnt
    );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage register chain with flush/stall/bubble, exception merge and bubble counting
module pipe_chain #(
    parameter int WIDTH    = 259,
    parameter int DEPTH    = 1,
    parameter int BASE     = 5,
    parameter int STALL_WD = 7,
    parameter int EXC_LO   = 150,
    parameter int EXC_WD   = 3,
    parameter int CNT_WD   = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_chain_if.slave p
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] merged;
    logic [OW-1:0]    occ;
    logic [CNT_WD-1:0] cnt;
    logic             bub;
    logic             unused_stall;

    assign unused_stall = ^p.stall;

    // late exception flags overwrite their field of the incoming payload
    always_comb begin
        merged = p.in_bus;
        merged[EXC_LO +: EXC_WD] = p.exc_in;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             s_k, s_n, src_v;
        logic [WIDTH-1:0] src_d;
        assign s_k = p.stall[BASE+k];
        assign s_n = p.stall[BASE+k+1];
        if (k == 0) begin : g_head
            assign src_d = merged;
            assign src_v = p.in_valid;
        end else begin : g_tail
            assign src_d = d[k-1];
            assign src_v = v[k-1];
        end
        // clear on reset/flush/bubble, load when not stalled, otherwise hold
        always_ff @(posedge clk) begin
            if (rst || p.flush || (s_k && !s_n)) begin
                d[k] <= '0;
                v[k] <= 1'b0;
            end else if (!s_k) begin
                d[k] <= src_d;
                v[k] <= src_v;
            end
        end
    end

    assign bub = p.stall[BASE] && !p.stall[BASE+1] && v[0] && !p.flush;

    // saturating count of bubbles that discarded a valid stage-0 entry
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (bub && cnt != '1)
            cnt <= cnt + CNT_WD'(1);
    end

    // popcount of stage valid bits
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++)
            occ = occ + OW'(v[i]);
    end

    assign p.out_bus    = d[DEPTH-1];
    assign p.out_valid  = v[DEPTH-1];
    assign p.occupancy  = occ;
    assign p.bubble_cnt = cnt;
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed self-checking bench for pipe_chain
module tb_pipe_chain;
    localparam int W = 259;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [W-1:0] e;

    always #5 clk = ~clk;

    pipe_chain_if #(.WIDTH(W), .DEPTH(2), .STALL_WD(7), .EXC_WD(3), .CNT_WD(16)) a ();
    pipe_chain_if #(.WIDTH(W), .DEPTH(1), .STALL_WD(7), .EXC_WD(3), .CNT_WD(16)) b ();
    pipe_chain_if #(.WIDTH(W), .DEPTH(1), .STALL_WD(7), .EXC_WD(3), .CNT_WD(4))  c ();

    pipe_chain #(.WIDTH(W), .DEPTH(2), .BASE(3), .STALL_WD(7), .EXC_LO(150), .EXC_WD(3), .CNT_WD(16))
        u_a (.clk(clk), .rst(rst), .p(a.slave));
    pipe_chain #(.WIDTH(W), .DEPTH(1), .BASE(5), .STALL_WD(7), .EXC_LO(150), .EXC_WD(3), .CNT_WD(16))
        u_b (.clk(clk), .rst(rst), .p(b.slave));
    pipe_chain #(.WIDTH(W), .DEPTH(1), .BASE(5), .STALL_WD(7), .EXC_LO(150), .EXC_WD(3), .CNT_WD(4))
        u_c (.clk(clk), .rst(rst), .p(c.slave));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a.flush = 0; a.stall = '0; a.in_bus = '0; a.in_valid = 0; a.exc_in = '0;
        b.flush = 0; b.stall = '0; b.in_bus = '0; b.in_valid = 0; b.exc_in = '0;
        c.flush = 0; c.stall = '0; c.in_bus = '0; c.in_valid = 0; c.exc_in = '0;
        step;
        check("rst_out_bus", a.out_bus, '0);
        check("rst_out_valid", W'(a.out_valid), '0);
        check("rst_occ", W'(a.occupancy), '0);
        check("rst_cnt", W'(a.bubble_cnt), '0);
        rst = 1'b0;

        a.in_valid = 1;
        for (int i = 1; i <= 7; i++) begin
            a.in_bus = W'(i);
            step;
            if (i == 1) check("run_occ_fill", W'(a.occupancy), W'(1));
            else begin
                check("run_out_bus", a.out_bus, W'(i - 1));
                check("run_occ", W'(a.occupancy), W'(2));
            end
        end

        a.stall = 7'b0001111;
        step;
        check("a_bub_cnt", W'(a.bubble_cnt), W'(1));
        check("a_bub_out", a.out_bus, W'(7));
        check("a_bub_occ", W'(a.occupancy), W'(1));

        a.stall = '0;
        a.in_bus = W'(8'hA5);
        step;
        step;
        check("fl_load_out", a.out_bus, W'(8'hA5));
        check("fl_load_occ", W'(a.occupancy), W'(2));
        a.flush = 1;
        a.stall = 7'b1111111;
        step;
        check("fl_out", a.out_bus, '0);
        check("fl_valid", W'(a.out_valid), '0);
        check("fl_occ", W'(a.occupancy), '0);
        check("fl_cnt", W'(a.bubble_cnt), W'(1));
        a.flush = 0;
        a.stall = '0;
        step;
        a.flush = 1;
        a.stall = 7'b0001111;
        step;
        check("fl_bub_occ", W'(a.occupancy), '0);
        check("fl_bub_cnt", W'(a.bubble_cnt), W'(1));
        a.flush = 0;
        a.stall = '0;
        rst = 1'b1;
        step;
        check("mid_rst_cnt", W'(a.bubble_cnt), '0);
        check("mid_rst_occ", W'(a.occupancy), '0);
        rst = 1'b0;

        b.in_bus = '1;
        b.exc_in = 3'b010;
        b.in_valid = 1;
        step;
        e = '1;
        e[152:150] = 3'b010;
        check("exc_out", b.out_bus, e);
        check("exc_valid", W'(b.out_valid), W'(1));

        b.stall = 7'b0111111;
        step;
        check("bub1_out", b.out_bus, '0);
        check("bub1_valid", W'(b.out_valid), '0);
        check("bub1_cnt", W'(b.bubble_cnt), W'(1));
        step;
        check("bub2_out", b.out_bus, '0);
        check("bub2_cnt", W'(b.bubble_cnt), W'(1));

        b.stall = '0;
        b.exc_in = '0;
        b.in_bus = W'(16'h1234);
        step;
        check("hold_load", b.out_bus, W'(16'h1234));
        b.stall = 7'b1111111;
        b.in_bus = W'(16'h5555);
        for (int i = 0; i < 3; i++) begin
            step;
            check("hold_out", b.out_bus, W'(16'h1234));
            check("hold_valid", W'(b.out_valid), W'(1));
        end
        b.stall = '0;
        step;
        check("release_out", b.out_bus, W'(16'h5555));

        c.in_valid = 1;
        for (int i = 0; i < 18; i++) begin
            c.stall = '0;
            step;
            c.stall = 7'b0111111;
            step;
            if (i == 2) check("sat_mid", W'(c.bubble_cnt), W'(3));
        end
        check("sat_cnt", W'(c.bubble_cnt), W'(4'hF));
        c.stall = '0;
        step;
        c.stall = 7'b0111111;
        step;
        check("sat_nowrap", W'(c.bubble_cnt), W'(4'hF));
        c.stall = '0;
        rst = 1'b1;
        step;
        check("sat_rst", W'(c.bubble_cnt), '0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised multi-stage pipeline register chain for the CPU datapath. It generalises the single stage-to-stage bus register to DEPTH consecutive stages, each driven by its own bit of the global stall bus. It injects late-arriving exception flags into a configurable field of the incoming bus and tracks per-stage valid bits, occupancy and a bubble count. It is used between address translation and memory access, and anywhere a stage boundary needs flush/stall/bubble handling.

## Interface
- WIDTH, 259: payload bus width in bits.
- DEPTH, 1: number of register stages, from 1 to 4.
- BASE, 5: stall bus index of stage 0. Stage k uses stall[BASE+k] and stall[BASE+k+1].
- STALL_WD, 7: stall bus width. Must satisfy BASE+DEPTH <= STALL_WD-1.
- EXC_LO, 150: lowest bit of the injected exception field.
- EXC_WD, 3: width of the exception field. Must be at least 1, and EXC_LO+EXC_WD <= WIDTH.
- clk  in  1  clock; every register updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clears every stage on the next edge.
- stall  in  STALL_WD  global stall bus; `Stop = 1, `NoStop = 0.
- in_bus  in  WIDTH  payload from the upstream stage.
- in_valid  in  1  in_bus carries a real instruction.
- exc_in  in  EXC_WD  exception flags, e.g. {modify, invalid, refill}, merged into stage 0.
- out_bus  out  WIDTH  payload of the last stage register.
- out_valid  out  1  valid bit of the last stage.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.
- bubble_cnt  out  16  saturating count of bubbles inserted at stage 0.

## Operation
- Each stage k holds a data register d[k] of WIDTH bits and a valid bit v[k].
- Let s_k = stall[BASE+k] and s_n = stall[BASE+k+1]. Per stage, per edge, apply the first rule that matches:
  1. rst: d[k] = 0, v[k] = 0.
  2. flush: d[k] = 0, v[k] = 0, for all stages in the same cycle.
  3. s_k == `Stop and s_n == `NoStop: insert a bubble. d[k] = 0, v[k] = 0.
  4. s_k == `NoStop: load from the source. v[k] takes the source valid.
  5. Otherwise: hold. d[k] and v[k] are unchanged.
- Load source for stage 0 is the merged input: in_bus with bits [EXC_LO+EXC_WD-1:EXC_LO] replaced by exc_in. All other in_bus bits pass unchanged. Source valid is in_valid.
- Load source for stage k>0 is d[k-1] and v[k-1], taken from the pre-edge values (a true shift).
- out_bus = d[DEPTH-1] and out_valid = v[DEPTH-1], driven directly from registers with no combinational path.
- occupancy is the combinational popcount of v[0..DEPTH-1].
- bubble_cnt:
  - Increments by 1 on each edge where stage 0 takes rule 3 and v[0] was 1 before the edge.
  - Saturates at 16'hFFFF.
  - Cleared only by rst; flush does not clear it.
- Stall bus contract: the bus is monotone (if stall[i] == `Stop then stall[j] == `Stop for all j < i). Behaviour on a non-monotone bus still follows the rules above per stage.

## Timing
- Reset values: out_bus = 0, out_valid = 0, occupancy = 0, bubble_cnt = 0.
- Latency: DEPTH cycles from in_bus to out_bus with no stalls, i.e. 1 cycle for DEPTH = 1.
- exc_in is sampled on the same edge as in_bus. No separate latency.
- flush asserted together with a stall: flush wins and all stages clear.
- rst asserted mid-operation: all state clears on that edge, including bubble_cnt.
- Bubble on an already-invalid stage: data is still zeroed, bubble_cnt is unchanged.
- Hold: out_bus stays bit-stable for as long as rule 5 applies.
- Throughput: 1 item per cycle when the whole stall bus is `NoStop.

## Test plan
- Reset, then free run with DEPTH = 2, BASE = 3, stall = 0, and in_bus = 1..5 with in_valid = 1 → out_bus shows 1..5 starting 2 cycles after the first input. occupancy = 2 in steady state.
- Exception merge with DEPTH = 1, BASE = 5: in_bus = all ones, exc_in = 3'b010 → out_bus[152:150] = 3'b010 one cycle later. All other bits are 1.
- Bubble with DEPTH = 1, BASE = 5: stall = 7'b0111111 (stall[5] = 1, stall[6] = 0) for 2 cycles with v[0] = 1 → out_bus = 0 and out_valid = 0. bubble_cnt rises by 1 on the first edge only, since the stage is invalid before the second edge.
- Hold: stall = 7'b1111111 for 3 cycles → out_bus and out_valid are unchanged. Release → the next in_bus loads on the following edge.
- Flush versus stall: load data 8'hA5 into both stages (DEPTH = 2), then assert flush together with stall = 7'b1111111 → both stages are 0 and occupancy = 0 on the next edge. bubble_cnt is unchanged.
- Saturation: force 65 540 bubble events → bubble_cnt = 16'hFFFF and does not wrap. A following rst → 0.
